vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Upstream video source for VGA_to_DVI_transmitter. It generates VGA-style raster timing (hsync, vsync, data-enable) and a built-in test pattern on the pixel clock. Its outputs drive the transmitter's VGA_r/g/b, VGA_hs, VGA_vs and VGA_de inputs directly. It also exports pixel coordinates and a frame-start strobe for a future framebuffer reader.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
CHECK_LOG2, 5, checkerboard square size is 2**CHECK_LOG2 pixels

Ports:
p_clk  in  1  pixel clock; the only clock
arstn  in  1  reset, synchronous, active-low
pattern_sel  in  2  0 colour bars, 1 checkerboard, 2 grey ramp, 3 solid white
VGA_r  out  8  red pixel
VGA_g  out  8  green pixel
VGA_b  out  8  blue pixel
VGA_hs  out  1  horizontal sync, polarity set by HS_POL
VGA_vs  out  1  vertical sync, polarity set by VS_POL
VGA_de  out  1  data enable, high in the active region
frame_start  out  1  one-cycle pulse aligned with pixel (0,0)
pix_x  out  12  column of the current output pixel
pix_y  out  12  row of the current output pixel

Behaviour:
- Derived values: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Defaults give 800x525.
- Stage 0 counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, and runs 0..V_TOTAL-1 before wrapping.
  - Both counters wrap on the same cycle at (H_TOTAL-1, V_TOTAL-1).
- Stage 1 registers every output. Latency from counter value to output is exactly 1 cycle; all outputs are mutually aligned.
- de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hs is active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vs is active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. vs changes only on h_cnt==0 cycles, since it is computed from v_cnt.
- frame_start = (h_cnt==0 && v_cnt==0).
- pix_x / pix_y are h_cnt / v_cnt registered. They are valid only while VGA_de=1.
- When de=0, RGB is forced to 0.
- pattern_sel is latched into pat_q on the h_cnt==0 && v_cnt==0 cycle only. Changes mid-frame take effect at the next frame, so there is no tearing. pat_q resets to 0.
- Colour bars (pattern 0):
  - Eight bars, in order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Bar width BW = H_ACTIVE/8.
  - Tracked with a bar_pos counter and a 3-bit bar_idx; no divider. Both reset at h_cnt==0. bar_idx advances when bar_pos hits BW-1.
  - bar_idx saturates at 7, covering any remainder pixels when H_ACTIVE is not a multiple of 8.
- Checkerboard (pattern 1): white if h_cnt[CHECK_LOG2] XOR v_cnt[CHECK_LOG2], else black.
- Grey ramp (pattern 2): r = g = b = h_cnt[7:0].
- Solid white (pattern 3): FFFFFF.
- Reset (arstn=0 sampled at a p_clk edge):
  - Counters, bar state and pat_q go to 0.
  - VGA_de=0, RGB=0, frame_start=0, pix_x=pix_y=0.
  - VGA_hs = ~HS_POL and VGA_vs = ~VS_POL (inactive levels).
  - Reset mid-frame aborts the frame immediately.
  - The first cycle after release has counters at (0,0); the next cycle outputs pixel (0,0) with de=1 and frame_start=1.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480@60 timing constants;
  - the 24-bit colour constants for the eight bars;
  - the pattern_sel encoding constants.
- One sub-module, vga_pattern_gen, is natural. It takes h_cnt, v_cnt and pat_q, and returns the combinational RGB plus its bar_pos/bar_idx state. The top level owns the counters, syncs and output registers.

Test Plan:
- Small timing (H 16/2/3/3, V 8/1/2/1, POL 0), reset 3 cycles then release -> first frame_start 2 cycles after release; hs low for 3 cycles every 24; vs low for exactly 2×24 cycles; de high for 16 of 24 cycles on lines 0..7.
- Default timing, pattern 0 -> line 0 pixels 0..79 = FFFFFF, pixel 80 = FFFF00, pixels 560..639 = 000000; RGB = 0 whenever de=0; frame period = 420000 cycles.
- pattern_sel changes 0→2 at mid-frame line 100 -> remainder of the frame stays bars; next frame pixel x=5 is 050505.
- Pattern 1, CHECK_LOG2=5 -> (0,0) black, (32,0) white, (32,32) black.
- Assert arstn at line 200 for 1 cycle -> next output has hs=vs=1, de=0; frame restarts at (0,0) two cycles after release.
- HS_POL=1, VS_POL=1 -> sync pulses high; idle level low, including during reset.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared types and constants for the VGA raster timing generator.
//   - Default 640x480@60 timing (800x525 total)
//   - 24-bit colours for the eight colour bars
//   - pattern_sel encoding
package vga_timing_pkg;

  localparam int unsigned CNT_W = 12;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t COL_WHITE   = 24'hFFFFFF;
  localparam rgb_t COL_YELLOW  = 24'hFFFF00;
  localparam rgb_t COL_CYAN    = 24'h00FFFF;
  localparam rgb_t COL_GREEN   = 24'h00FF00;
  localparam rgb_t COL_MAGENTA = 24'hFF00FF;
  localparam rgb_t COL_RED     = 24'hFF0000;
  localparam rgb_t COL_BLUE    = 24'h0000FF;
  localparam rgb_t COL_BLACK   = 24'h000000;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_WHITE = 2'd3
  } pat_e;

  // Colour of bar idx, left to right.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return COL_WHITE;
      3'd1:    return COL_YELLOW;
      3'd2:    return COL_CYAN;
      3'd3:    return COL_GREEN;
      3'd4:    return COL_MAGENTA;
      3'd5:    return COL_RED;
      3'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// VGA video bus between the timing generator and the DVI transmitter.
//   master: drives VGA_r/g/b, VGA_hs, VGA_vs, VGA_de, frame_start, pix_x, pix_y;
//           receives pattern_sel
//   slave : the opposite direction
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic [1:0]       pattern_sel;
  logic [7:0]       VGA_r;
  logic [7:0]       VGA_g;
  logic [7:0]       VGA_b;
  logic             VGA_hs;
  logic             VGA_vs;
  logic             VGA_de;
  logic             frame_start;
  logic [CNT_W-1:0] pix_x;
  logic [CNT_W-1:0] pix_y;

  modport master (
    input  pattern_sel,
    output VGA_r, VGA_g, VGA_b, VGA_hs, VGA_vs, VGA_de, frame_start, pix_x, pix_y
  );

  modport slave (
    output pattern_sel,
    input  VGA_r, VGA_g, VGA_b, VGA_hs, VGA_vs, VGA_de, frame_start, pix_x, pix_y
  );

endinterface

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator. Produces the combinational colour for the pixel at
// (i_h_cnt, i_v_cnt), already blanked to black outside the active region.
//   i_clk, i_rst_n : pixel clock, synchronous active-low reset
//   i_h_cnt/i_v_cnt: stage-0 raster counters
//   i_pat          : pattern in effect for this frame
//   o_rgb_c        : combinational colour
module vga_pattern_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned H_TOTAL    = 800,
  parameter int unsigned CHECK_LOG2 = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [CNT_W-1:0] i_h_cnt,
  input  logic [CNT_W-1:0] i_v_cnt,
  input  pat_e             i_pat,
  output rgb_t             o_rgb_c
);

  localparam int unsigned BW = H_ACTIVE / 8;

  logic [CNT_W-1:0] r_bar_pos;
  logic [2:0]       r_bar_idx;
  logic             w_h_last;
  logic             w_active;

  assign w_h_last = (i_h_cnt == CNT_W'(H_TOTAL - 1));
  assign w_active = (i_h_cnt < CNT_W'(H_ACTIVE)) && (i_v_cnt < CNT_W'(V_ACTIVE));

  // Bar tracker: zero whenever h_cnt is zero; idx saturates to absorb remainder pixels.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || w_h_last) begin
      r_bar_pos <= '0;
      r_bar_idx <= '0;
    end else if (r_bar_pos == CNT_W'(BW - 1)) begin
      r_bar_pos <= '0;
      if (r_bar_idx != 3'd7) r_bar_idx <= r_bar_idx + 3'd1;
    end else begin
      r_bar_pos <= r_bar_pos + CNT_W'(1);
    end
  end

  // Pattern select and blanking.
  always_comb begin
    o_rgb_c = COL_BLACK;
    if (w_active) begin
      case (i_pat)
        PAT_BARS:  o_rgb_c = bar_colour(r_bar_idx);
        PAT_CHECK: o_rgb_c = (i_h_cnt[CHECK_LOG2] ^ i_v_cnt[CHECK_LOG2]) ? COL_WHITE : COL_BLACK;
        PAT_RAMP:  o_rgb_c = rgb_t'({3{i_h_cnt[7:0]}});
        PAT_WHITE: o_rgb_c = COL_WHITE;
        default:   o_rgb_c = COL_BLACK;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with built-in test patterns.
//   p_clk : pixel clock
//   arstn : synchronous active-low reset
//   vga   : master side of the video bus (pattern_sel in; RGB, syncs,
//           data enable, frame_start, pix_x/pix_y out, all registered)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned CHECK_LOG2 = 5
) (
  input  logic               p_clk,
  input  logic               arstn,
  vga_timing_gen_if.master   vga
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  pat_e             r_pat_q;
  rgb_t             r_rgb;
  logic             r_hs;
  logic             r_vs;
  logic             r_de;
  logic             r_fs;
  logic [CNT_W-1:0] r_pix_x;
  logic [CNT_W-1:0] r_pix_y;

  logic             w_h_last;
  logic             w_v_last;
  logic             w_frame0;
  logic             w_de;
  logic             w_hs_act;
  logic             w_vs_act;
  pat_e             w_pat;
  rgb_t             w_rgb;

  assign w_h_last = (r_h_cnt == CNT_W'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == CNT_W'(V_TOTAL - 1));
  assign w_frame0 = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_de     = (r_h_cnt < CNT_W'(H_ACTIVE)) && (r_v_cnt < CNT_W'(V_ACTIVE));
  assign w_hs_act = (r_h_cnt >= CNT_W'(HS_START)) && (r_h_cnt < CNT_W'(HS_END));
  assign w_vs_act = (r_v_cnt >= CNT_W'(VS_START)) && (r_v_cnt < CNT_W'(VS_END));

  // On the frame-start cycle the incoming selection is used directly so that
  // pixel (0,0) already belongs to the new frame's pattern.
  assign w_pat = w_frame0 ? pat_e'(vga.pattern_sel) : r_pat_q;

  // Stage 0: raster counters.
  always_ff @(posedge p_clk) begin
    if (!arstn) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
    end else begin
      r_h_cnt <= r_h_cnt + CNT_W'(1);
    end
  end

  // Pattern is held for a whole frame to avoid tearing.
  always_ff @(posedge p_clk) begin
    if (!arstn)        r_pat_q <= PAT_BARS;
    else if (w_frame0) r_pat_q <= w_pat;
  end

  vga_pattern_gen #(
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .H_TOTAL    (H_TOTAL),
    .CHECK_LOG2 (CHECK_LOG2)
  ) u_pattern (
    .i_clk   (p_clk),
    .i_rst_n (arstn),
    .i_h_cnt (r_h_cnt),
    .i_v_cnt (r_v_cnt),
    .i_pat   (w_pat),
    .o_rgb_c (w_rgb)
  );

  // Stage 1: every output registered, one cycle behind the counters.
  always_ff @(posedge p_clk) begin
    if (!arstn) begin
      r_rgb   <= COL_BLACK;
      r_hs    <= ~HS_POL;
      r_vs    <= ~VS_POL;
      r_de    <= 1'b0;
      r_fs    <= 1'b0;
      r_pix_x <= '0;
      r_pix_y <= '0;
    end else begin
      r_rgb   <= w_rgb;
      r_hs    <= w_hs_act ? HS_POL : ~HS_POL;
      r_vs    <= w_vs_act ? VS_POL : ~VS_POL;
      r_de    <= w_de;
      r_fs    <= w_frame0;
      r_pix_x <= r_h_cnt;
      r_pix_y <= r_v_cnt;
    end
  end

  assign vga.VGA_r       = r_rgb.r;
  assign vga.VGA_g       = r_rgb.g;
  assign vga.VGA_b       = r_rgb.b;
  assign vga.VGA_hs      = r_hs;
  assign vga.VGA_vs      = r_vs;
  assign vga.VGA_de      = r_de;
  assign vga.frame_start = r_fs;
  assign vga.pix_x       = r_pix_x;
  assign vga.pix_y       = r_pix_y;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: stimulus pushes (cycle, expected outputs) entries; a
// negedge monitor compares each entry when its cycle's output is presented.
// dut_d: 800-pixel lines, 12-line frames, CHECK_LOG2=2
// dut_s: small 24x12 timing, active-low syncs
// dut_p: small timing, active-high syncs
module tb_vga_timing_gen;

  typedef struct packed {
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [11:0] x;
    logic [11:0] y;
  } obs_t;

  typedef struct {
    int    cyc;
    int    dut;
    obs_t  e;
    string nm;
  } exp_t;

  logic clk = 1'b0;
  logic rstn_d, rstn_s, rstn_p;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   s_de = 0, s_hs = 0, s_vs = 0;
  int   d_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_timing_gen_if if_d ();
  vga_timing_gen_if if_s ();
  vga_timing_gen_if if_p ();

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CHECK_LOG2(2)
  ) dut_d (.p_clk(clk), .arstn(rstn_d), .vga(if_d));

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CHECK_LOG2(1)
  ) dut_s (.p_clk(clk), .arstn(rstn_s), .vga(if_s));

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CHECK_LOG2(1)
  ) dut_p (.p_clk(clk), .arstn(rstn_p), .vga(if_p));

  function automatic obs_t mk(input int x, input int y, input logic [23:0] rgb,
                              input logic de, input logic hs, input logic vs, input logic fs);
    obs_t o;
    o.rgb = rgb; o.de = de; o.hs = hs; o.vs = vs; o.fs = fs;
    o.x = 12'(x); o.y = 12'(y);
    return o;
  endfunction

  function automatic obs_t obs_of(input int id);
    obs_t o;
    o = '0;
    case (id)
      0: begin
        o.rgb = {if_d.VGA_r, if_d.VGA_g, if_d.VGA_b};
        o.de = if_d.VGA_de; o.hs = if_d.VGA_hs; o.vs = if_d.VGA_vs;
        o.fs = if_d.frame_start; o.x = if_d.pix_x; o.y = if_d.pix_y;
      end
      1: begin
        o.rgb = {if_s.VGA_r, if_s.VGA_g, if_s.VGA_b};
        o.de = if_s.VGA_de; o.hs = if_s.VGA_hs; o.vs = if_s.VGA_vs;
        o.fs = if_s.frame_start; o.x = if_s.pix_x; o.y = if_s.pix_y;
      end
      default: begin
        o.rgb = {if_p.VGA_r, if_p.VGA_g, if_p.VGA_b};
        o.de = if_p.VGA_de; o.hs = if_p.VGA_hs; o.vs = if_p.VGA_vs;
        o.fs = if_p.frame_start; o.x = if_p.pix_x; o.y = if_p.pix_y;
      end
    endcase
    return o;
  endfunction

  task automatic expect_at(input int dut, input int c, input string nm, input obs_t e);
    exp_t t;
    t.cyc = c; t.dut = dut; t.e = e; t.nm = nm;
    sb.push_back(t);
  endtask

  // Active pixel on dut_d (syncs inactive), relative to frame base cycle.
  task automatic act_d(input int base, input int x, input int y, input logic [23:0] rgb,
                       input string nm);
    expect_at(0, base + y * 800 + x, nm, mk(x, y, rgb, 1'b1, 1'b1, 1'b1, (x == 0 && y == 0)));
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  // Monitor: compare every scoreboard entry due this cycle.
  always @(negedge clk) begin
    obs_t a;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        a = obs_of(sb[i].dut);
        n_chk++;
        if (sb[i].cyc < cyc) begin
          n_fail++;
          $display("FAIL %s: entry for cycle %0d not checked in time (now %0d)", sb[i].nm, sb[i].cyc, cyc);
        end else if (a !== sb[i].e) begin
          n_fail++;
          $display("FAIL %s @%0d: got rgb=%06h de=%0b hs=%0b vs=%0b fs=%0b x=%0d y=%0d, want rgb=%06h de=%0b hs=%0b vs=%0b fs=%0b x=%0d y=%0d",
                   sb[i].nm, cyc, a.rgb, a.de, a.hs, a.vs, a.fs, a.x, a.y,
                   sb[i].e.rgb, sb[i].e.de, sb[i].e.hs, sb[i].e.vs, sb[i].e.fs, sb[i].e.x, sb[i].e.y);
        end
        sb.delete(i);
      end
    end
    // One full frame of dut_s after release at cycle 4.
    if (cyc >= 4 && cyc < 4 + 288) begin
      if (if_s.VGA_de)  s_de++;
      if (!if_s.VGA_hs) s_hs++;
      if (!if_s.VGA_vs) s_vs++;
    end
    if (cyc >= 1 && !if_d.VGA_de && {if_d.VGA_r, if_d.VGA_g, if_d.VGA_b} != 24'h0) d_bad++;
  end

  // Small-timing DUTs: reset state, sync placement, polarity.
  initial begin
    rstn_s = 1'b0; rstn_p = 1'b0;
    if_s.pattern_sel = 2'd3;
    if_p.pattern_sel = 2'd3;
    expect_at(1, 2,   "s_reset",     mk(0, 0, 24'h0, 0, 1, 1, 0));
    expect_at(2, 2,   "p_reset",     mk(0, 0, 24'h0, 0, 0, 0, 0));
    expect_at(1, 4,   "s_first_px",  mk(0, 0, 24'hFFFFFF, 1, 1, 1, 1));
    expect_at(1, 19,  "s_last_act",  mk(15, 0, 24'hFFFFFF, 1, 1, 1, 0));
    expect_at(1, 20,  "s_first_bl",  mk(16, 0, 24'h0, 0, 1, 1, 0));
    expect_at(1, 21,  "s_hs_pre",    mk(17, 0, 24'h0, 0, 1, 1, 0));
    expect_at(1, 22,  "s_hs_on",     mk(18, 0, 24'h0, 0, 0, 1, 0));
    expect_at(1, 24,  "s_hs_last",   mk(20, 0, 24'h0, 0, 0, 1, 0));
    expect_at(1, 25,  "s_hs_off",    mk(21, 0, 24'h0, 0, 1, 1, 0));
    expect_at(1, 28,  "s_line1",     mk(0, 1, 24'hFFFFFF, 1, 1, 1, 0));
    expect_at(1, 196, "s_vblank",    mk(0, 8, 24'h0, 0, 1, 1, 0));
    expect_at(1, 219, "s_vs_pre",    mk(23, 8, 24'h0, 0, 1, 1, 0));
    expect_at(1, 220, "s_vs_on",     mk(0, 9, 24'h0, 0, 1, 0, 0));
    expect_at(1, 267, "s_vs_last",   mk(23, 10, 24'h0, 0, 1, 0, 0));
    expect_at(1, 268, "s_vs_off",    mk(0, 11, 24'h0, 0, 1, 1, 0));
    expect_at(1, 292, "s_frame2",    mk(0, 0, 24'hFFFFFF, 1, 1, 1, 1));
    expect_at(2, 4,   "p_first_px",  mk(0, 0, 24'hFFFFFF, 1, 0, 0, 1));
    expect_at(2, 22,  "p_hs_on",     mk(18, 0, 24'h0, 0, 1, 0, 0));
    expect_at(2, 220, "p_vs_on",     mk(0, 9, 24'h0, 0, 0, 1, 0));
    wait_until(3);
    rstn_s = 1'b1; rstn_p = 1'b1;
  end

  // Default-width DUT: bars, pattern switching, mid-frame reset, then summary.
  initial begin
    int k, f1, f2, f3, c1, k2;
    rstn_d = 1'b0;
    if_d.pattern_sel = 2'd0;
    k = 4;
    act_d(k, 0,   0, 24'hFFFFFF, "d_bar_white0");
    act_d(k, 79,  0, 24'hFFFFFF, "d_bar_white79");
    act_d(k, 80,  0, 24'hFFFF00, "d_bar_yellow80");
    act_d(k, 159, 0, 24'hFFFF00, "d_bar_yellow159");
    act_d(k, 160, 0, 24'h00FFFF, "d_bar_cyan");
    act_d(k, 240, 0, 24'h00FF00, "d_bar_green");
    act_d(k, 320, 0, 24'hFF00FF, "d_bar_magenta");
    act_d(k, 400, 0, 24'hFF0000, "d_bar_red");
    act_d(k, 480, 0, 24'h0000FF, "d_bar_blue");
    act_d(k, 560, 0, 24'h000000, "d_bar_black560");
    act_d(k, 639, 0, 24'h000000, "d_bar_black639");
    expect_at(0, k + 640, "d_hblank",  mk(640, 0, 24'h0, 0, 1, 1, 0));
    expect_at(0, k + 655, "d_hs_pre",  mk(655, 0, 24'h0, 0, 1, 1, 0));
    expect_at(0, k + 656, "d_hs_on",   mk(656, 0, 24'h0, 0, 0, 1, 0));
    expect_at(0, k + 751, "d_hs_last", mk(751, 0, 24'h0, 0, 0, 1, 0));
    expect_at(0, k + 752, "d_hs_off",  mk(752, 0, 24'h0, 0, 1, 1, 0));
    act_d(k, 100, 1, 24'hFFFF00, "d_line1_bar");
    wait_until(1);
    expect_at(0, 2, "d_reset", mk(0, 0, 24'h0, 0, 1, 1, 0));
    wait_until(3);
    rstn_d = 1'b1;

    // Switch to ramp mid-frame: current frame stays bars.
    wait_until(k + 2 * 800 + 300);
    if_d.pattern_sel = 2'd2;
    f1 = k + 9600;
    act_d(k, 100, 5, 24'hFFFF00, "d_no_tear");
    act_d(f1, 5,   0, 24'h050505, "d_ramp5");
    act_d(f1, 300, 0, 24'h2C2C2C, "d_ramp300");
    act_d(f1, 200, 3, 24'hC8C8C8, "d_ramp200");

    // Switch to checkerboard for the following frame.
    wait_until(f1 + 4 * 800);
    if_d.pattern_sel = 2'd1;
    f2 = f1 + 9600;
    expect_at(0, f2 - 1, "d_frame_end", mk(799, 11, 24'h0, 0, 1, 1, 0));
    act_d(f2, 0, 0, 24'h000000, "d_chk_0_0");
    act_d(f2, 4, 0, 24'hFFFFFF, "d_chk_4_0");
    act_d(f2, 0, 4, 24'hFFFFFF, "d_chk_0_4");
    act_d(f2, 4, 4, 24'h000000, "d_chk_4_4");

    // Back to bars for later, then reset mid-frame on line 3.
    f3 = f2 + 9600;
    wait_until(f3 + 800);
    if_d.pattern_sel = 2'd0;
    act_d(f3, 100, 3, 24'hFFFFFF, "d_pre_rst");
    wait_until(f3 + 2500);
    rstn_d = 1'b0;
    c1 = f3 + 2501;
    expect_at(0, c1, "d_mid_reset", mk(0, 0, 24'h0, 0, 1, 1, 0));
    wait_until(c1);
    rstn_d = 1'b1;
    k2 = c1 + 1;
    act_d(k2, 0,  0, 24'hFFFFFF, "d_restart");
    act_d(k2, 80, 0, 24'hFFFF00, "d_restart_bar");
    act_d(k2 + 9600, 0, 0, 24'hFFFFFF, "d_restart_period");

    wait_until(k2 + 9600 + 10);
    check_int("sb_drained", sb.size(), 0);
    check_int("s_de_cycles", s_de, 128);
    check_int("s_hs_cycles", s_hs, 36);
    check_int("s_vs_cycles", s_vs, 48);
    check_int("d_rgb_blank", d_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
